lsu_apb: RTL

LSU_APB -- requirements
Module: lsu_apb

---
 rtl/lsu_apb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_apb.sv
// Load/store unit bridging a single CPU request to an APB-style bus.
// Handles lane strobes, store replication, load extraction/extension and a wait timeout.
module lsu_apb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [1:0]              cpu_size,
  input  logic                    cpu_unsigned,
  output logic                    cpu_busy,
  output logic                    cpu_done,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [DATA_WIDTH-1:0]   pdata,
  input  logic [DATA_WIDTH-1:0]   prdata,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH/8-1:0] pstb,
  input  logic                    pready,
  input  logic                    perr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state_r;
  logic [1:0]            size_r;
  logic                  unsigned_r;
  logic [CNT_W-1:0]      tmo_cnt_r;
  logic                  fin_r;
  logic                  fin_err_r;
  logic [DATA_WIDTH-1:0] fin_data_r;

  logic                  illegal_s;
  logic [STRB_W-1:0]     req_strb_s;
  logic [DATA_WIDTH-1:0] req_data_s;
  logic [DATA_WIDTH-1:0] shifted_s;
  logic [DATA_WIDTH-1:0] load_data_s;
  logic                  tmo_hit_s;
  logic                  accept_s;

  // Request decode: legality, lane strobes and replicated store data.
  always_comb begin
    illegal_s  = 1'b0;
    req_strb_s = '0;
    req_data_s = cpu_wdata;
    case (cpu_size)
      2'b00: begin
        req_strb_s = STRB_W'(1'b1) << cpu_addr[1:0];
        req_data_s = {(DATA_WIDTH/8){cpu_wdata[7:0]}};
      end
      2'b01: begin
        illegal_s  = cpu_addr[0];
        req_strb_s = STRB_W'(2'b11) << cpu_addr[1:0];
        req_data_s = {(DATA_WIDTH/16){cpu_wdata[15:0]}};
      end
      2'b10: begin
        illegal_s  = (cpu_addr[1:0] != 2'b00);
        req_strb_s = '1;
        req_data_s = cpu_wdata;
      end
      default: begin
        illegal_s  = 1'b1;
        req_strb_s = '0;
        req_data_s = cpu_wdata;
      end
    endcase
  end

  // Load extraction: align the addressed lane to bit 0, then extend.
  always_comb begin
    shifted_s = prdata >> {paddr[1:0], 3'b000};
    case (size_r)
      2'b00: begin
        if (unsigned_r) begin
          load_data_s = {{(DATA_WIDTH-8){1'b0}}, shifted_s[7:0]};
        end else begin
          load_data_s = {{(DATA_WIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
        end
      end
      2'b01: begin
        if (unsigned_r) begin
          load_data_s = {{(DATA_WIDTH-16){1'b0}}, shifted_s[15:0]};
        end else begin
          load_data_s = {{(DATA_WIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
        end
      end
      default: load_data_s = shifted_s;
    endcase
  end

  // Requests are refused while a completion is still being reported so done never stretches.
  assign accept_s  = cpu_req && !fin_r && !cpu_done;
  assign tmo_hit_s = (TIMEOUT != 0) && !pready && (tmo_cnt_r == CNT_W'(TIMEOUT - 1));

  // Bus FSM, request capture and the one-cycle-delayed completion report.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_r    <= ST_IDLE;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      tmo_cnt_r  <= '0;
      fin_r      <= 1'b0;
      fin_err_r  <= 1'b0;
      fin_data_r <= '0;
      cpu_busy   <= 1'b0;
      cpu_done   <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_rdata  <= '0;
      paddr      <= '0;
      pdata      <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      pstb       <= '0;
    end else begin
      fin_r    <= 1'b0;
      cpu_done <= fin_r;
      if (fin_r) begin
        cpu_err   <= fin_err_r;
        cpu_rdata <= fin_data_r;
      end else begin
        cpu_err   <= 1'b0;
        cpu_rdata <= '0;
      end

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            paddr      <= cpu_addr;
            pdata      <= req_data_s;
            pwrite     <= cpu_we;
            pstb       <= req_strb_s;
            size_r     <= cpu_size;
            unsigned_r <= cpu_unsigned;
            if (illegal_s) begin
              fin_r      <= 1'b1;
              fin_err_r  <= 1'b1;
              fin_data_r <= '0;
            end else begin
              state_r  <= ST_SETUP;
              psel     <= 1'b1;
              cpu_busy <= 1'b1;
            end
          end
        end
        ST_SETUP: begin
          state_r   <= ST_ACCESS;
          penable   <= 1'b1;
          tmo_cnt_r <= '0;
        end
        ST_ACCESS: begin
          if (pready) begin
            state_r   <= ST_IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            cpu_busy  <= 1'b0;
            fin_r     <= 1'b1;
            fin_err_r <= perr;
            if (perr || pwrite) begin
              fin_data_r <= '0;
            end else begin
              fin_data_r <= load_data_s;
            end
          end else if (tmo_hit_s) begin
            state_r    <= ST_IDLE;
            psel       <= 1'b0;
            penable    <= 1'b0;
            cpu_busy   <= 1'b0;
            fin_r      <= 1'b1;
            fin_err_r  <= 1'b1;
            fin_data_r <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          psel     <= 1'b0;
          penable  <= 1'b0;
          cpu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
